rst_seq_gen: RTL and testbench
==============================

Name: rst_seq_gen

Overview:
Synthesizable, parametrised reset sequencer and clock-enable generator for the S1D13700 core.
- Releases NCH active-low domain resets in a staggered order after a programmable hold time.
- Optional double-pulse mode: release, re-assert, then release again.
- After the sequence completes, asserts a ready flag and a divided clock-enable tick.
- Sits at the top level between the pad reset/clock and every functional domain.

Parameters:
NCH, 4, number of reset channels (1..8)
CNT_W, 8, width of the internal cycle counter
HOLD, 28, cycles all channels stay asserted before the first release (1..2^CNT_W-1)
STEP, 4, cycles between successive channel releases (1..2^CNT_W-1)
PULSE, 14, cycles fully released before re-assertion in double-pulse mode (1..2^CNT_W-1)
DIV, 4, clock-enable divide ratio (2..2^CNT_W-1)

Ports:
P_MCLK  in  1  system clock, rising edge
P_RST  in  1  asynchronous, active-high reset
P_DBL_MODE  in  1  double-pulse select; latched once per sequence (see Behaviour)
P_SRST_REQ  in  1  synchronous soft-reset request, active high
P_RST_X  out  NCH  active-low channel resets; bit 0 released first
P_READY  out  1  high when the sequence is complete
P_CKEN  out  1  one-cycle enable, one pulse every DIV cycles while ready
P_STATE  out  2  debug state: 0 HOLD, 1 STAGE, 2 PULSE, 3 DONE

Behaviour:
- Async reset (P_RST=1) forces: P_RST_X=0, P_READY=0, P_CKEN=0, state HOLD, cnt=0, idx=0, pass=0, dbl_r=0.
- All outputs are registered. Edge n means the n-th rising P_MCLK edge after P_RST falls.
- HOLD:
  - cnt increments each edge.
  - When cnt==HOLD-1: go to STAGE, cnt=0, P_RST_X[0]=1.
  - If pass==0, latch dbl_r=P_DBL_MODE on the same edge.
- STAGE:
  - cnt increments each edge.
  - When cnt==STEP-1: cnt=0, idx++, P_RST_X[idx+1]=1.
  - Bit k is released at edge HOLD+k*STEP. Released bits stay 1.
  - After bit NCH-1 has been released, on the next edge where cnt==STEP-1:
    - If dbl_r=1 and pass==0: go to PULSE.
    - Otherwise: go to DONE and set P_READY=1.
  - With NCH=1, the first-release edge is the only release; the STEP wait then applies.
- PULSE:
  - Counts PULSE cycles.
  - Then all P_RST_X=0, pass=1, idx=0, cnt=0, and go to HOLD.
  - The second pass repeats HOLD and STAGE exactly, then goes to DONE.
- DONE:
  - P_READY=1.
  - Divider dcnt counts 0..DIV-1 and wraps.
  - P_CKEN=1 for exactly one cycle when dcnt==DIV-1.
  - The first P_CKEN occurs DIV edges after P_READY rises.
  - In all other states, dcnt=0 and P_CKEN=0.
- Soft reset:
  - P_SRST_REQ=1 at any edge, in any state, has priority over all transitions.
  - Next values: P_RST_X=0, P_READY=0, P_CKEN=0, state HOLD, cnt=0, idx=0, pass=0.
  - The sequence restarts; P_DBL_MODE is re-latched at the end of the new first HOLD.
  - A request held high keeps the block in HOLD with cnt=0.
- P_DBL_MODE changes after latching have no effect until the next reset or soft reset.
- Async reset asserted mid-sequence: immediate return to reset values, no glitching of released bits beyond the asynchronous clear.
- Parameter violations are elaboration errors, not runtime behaviour.

Test Plan:
- Defaults, P_DBL_MODE=0, P_RST pulse then low:
  - P_RST_X goes 0001 at edge 28, 0011 at 32, 0111 at 36, 1111 at 40.
  - P_READY=1 at edge 44.
  - P_CKEN pulses at edges 48, 52, 56.
- Defaults, P_DBL_MODE=1:
  - First pass as above up to 1111 at edge 40.
  - P_RST_X=0000 at edge 58.
  - Second pass releases 0001 at 86, 1111 at 98.
  - P_READY at 102.
- P_SRST_REQ for one cycle at edge 34 (state STAGE, P_RST_X=0011):
  - Next edge P_RST_X=0000, P_STATE=0.
  - Bit 0 re-released 28 edges later.
- P_SRST_REQ during DONE:
  - P_READY and P_CKEN drop on the next edge.
  - Full sequence replays with new P_DBL_MODE.
- P_RST asserted asynchronously mid-cycle during PULSE:
  - All outputs go 0 before the next edge.
  - After release, single-pass sequence (dbl_r cleared).
- NCH=1, HOLD=1, STEP=1, DIV=2 corner:
  - P_RST_X=1 at edge 1.
  - P_READY at edge 2.
  - P_CKEN at edges 4, 6, 8.

Source files
------------

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staggered reset sequencer and clock-enable generator.
// Releases NCH active-low domain resets one after another after a hold time,
// optionally runs a second release pass, then raises a ready flag and a
// divided clock-enable tick.
//
// Ports:
//   P_MCLK      in   system clock, rising edge
//   P_RST       in   asynchronous active-high reset
//   P_DBL_MODE  in   double-pulse select, latched at the end of the first HOLD
//   P_SRST_REQ  in   synchronous soft-reset request, active high
//   P_RST_X     out  [NCH-1:0] active-low channel resets, bit 0 released first
//   P_READY     out  high once the sequence has completed
//   P_CKEN      out  one-cycle enable every DIV cycles while ready
//   P_STATE     out  [1:0] debug state: 0 HOLD, 1 STAGE, 2 PULSE, 3 DONE
module rst_seq_gen #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int HOLD  = 28,
    parameter int STEP  = 4,
    parameter int PULSE = 14,
    parameter int DIV   = 4
) (
    input  logic           P_MCLK,
    input  logic           P_RST,
    input  logic           P_DBL_MODE,
    input  logic           P_SRST_REQ,
    output logic [NCH-1:0] P_RST_X,
    output logic           P_READY,
    output logic           P_CKEN,
    output logic [1:0]     P_STATE
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] STEP_M1  = CNT_W'(STEP - 1);
    localparam logic [CNT_W-1:0] PULSE_M1 = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] DIV_M1   = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    // Out-of-range parameters stop elaboration.
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $error("rst_seq_gen: NCH must be 1..8");
    end
    if (HOLD < 1 || HOLD > CMAX) begin : g_bad_hold
        $error("rst_seq_gen: HOLD out of range");
    end
    if (STEP < 1 || STEP > CMAX) begin : g_bad_step
        $error("rst_seq_gen: STEP out of range");
    end
    if (PULSE < 1 || PULSE > CMAX) begin : g_bad_pulse
        $error("rst_seq_gen: PULSE out of range");
    end
    if (DIV < 2 || DIV > CMAX) begin : g_bad_div
        $error("rst_seq_gen: DIV out of range");
    end

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_STAGE = 2'd1,
        S_PULSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_dcnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_pass;
    logic             r_dbl;
    logic [NCH-1:0]   r_rst_x;
    logic             r_ready;
    logic             r_cken;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_dcnt;
    logic [IDX_W-1:0] w_idx;
    logic             w_pass;
    logic             w_dbl;
    logic [NCH-1:0]   w_rst_x;
    logic             w_ready;
    logic             w_cken;

    always_ff @(posedge P_MCLK or posedge P_RST) begin
        if (P_RST) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_dbl   <= 1'b0;
            r_rst_x <= '0;
            r_ready <= 1'b0;
            r_cken  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_dcnt  <= w_dcnt;
            r_idx   <= w_idx;
            r_pass  <= w_pass;
            r_dbl   <= w_dbl;
            r_rst_x <= w_rst_x;
            r_ready <= w_ready;
            r_cken  <= w_cken;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + CNT_W'(1);
        w_dcnt  = '0;
        w_idx   = r_idx;
        w_pass  = r_pass;
        w_dbl   = r_dbl;
        w_rst_x = r_rst_x;
        w_ready = 1'b0;
        w_cken  = 1'b0;

        unique case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_M1) begin
                    w_state    = S_STAGE;
                    w_cnt      = '0;
                    w_rst_x[0] = 1'b1;
                    // Mode is sampled only on the first pass so the
                    // second pass cannot be cancelled midway.
                    if (!r_pass) begin
                        w_dbl = P_DBL_MODE;
                    end
                end
            end
            S_STAGE: begin
                if (r_cnt == STEP_M1) begin
                    w_cnt = '0;
                    if (r_idx == LAST_IDX) begin
                        if (r_dbl && !r_pass) begin
                            w_state = S_PULSE;
                        end else begin
                            w_state = S_DONE;
                            w_ready = 1'b1;
                        end
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                        for (int k = 0; k < NCH; k++) begin
                            if (k == int'(r_idx) + 1) begin
                                w_rst_x[k] = 1'b1;
                            end
                        end
                    end
                end
            end
            S_PULSE: begin
                if (r_cnt == PULSE_M1) begin
                    w_state = S_HOLD;
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_pass  = 1'b1;
                    w_rst_x = '0;
                end
            end
            S_DONE: begin
                w_cnt   = r_cnt;
                w_ready = 1'b1;
                w_cken  = (r_dcnt == DIV_M1);
                w_dcnt  = (r_dcnt == DIV_M1) ? '0 : r_dcnt + CNT_W'(1);
            end
            default: begin
                w_state = S_HOLD;
            end
        endcase

        // Soft reset overrides every transition; dbl_r is left alone and
        // simply re-latched at the end of the new first HOLD.
        if (P_SRST_REQ) begin
            w_state = S_HOLD;
            w_cnt   = '0;
            w_dcnt  = '0;
            w_idx   = '0;
            w_pass  = 1'b0;
            w_rst_x = '0;
            w_ready = 1'b0;
            w_cken  = 1'b0;
        end
    end

    assign P_RST_X = r_rst_x;
    assign P_READY = r_ready;
    assign P_CKEN  = r_cken;
    assign P_STATE = r_state;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed testbench for rst_seq_gen: default-parameter instance plus a
// NCH=1/HOLD=1/STEP=1/DIV=2 corner instance sharing one clock.
module tb_rst_seq_gen;

    logic       clk;
    logic       rst_a;
    logic       dbl_a;
    logic       srst_a;
    logic [3:0] rx_a;
    logic       rdy_a;
    logic       ck_a;
    logic [1:0] st_a;

    logic       rst_b;
    logic       dbl_b;
    logic       srst_b;
    logic [0:0] rx_b;
    logic       rdy_b;
    logic       ck_b;
    logic [1:0] st_b;

    int n_vec;
    int n_err;

    rst_seq_gen u_a (
        .P_MCLK     (clk),
        .P_RST      (rst_a),
        .P_DBL_MODE (dbl_a),
        .P_SRST_REQ (srst_a),
        .P_RST_X    (rx_a),
        .P_READY    (rdy_a),
        .P_CKEN     (ck_a),
        .P_STATE    (st_a)
    );

    rst_seq_gen #(
        .NCH   (1),
        .CNT_W (8),
        .HOLD  (1),
        .STEP  (1),
        .PULSE (14),
        .DIV   (2)
    ) u_b (
        .P_MCLK     (clk),
        .P_RST      (rst_b),
        .P_DBL_MODE (dbl_b),
        .P_SRST_REQ (srst_b),
        .P_RST_X    (rx_b),
        .P_READY    (rdy_b),
        .P_CKEN     (ck_b),
        .P_STATE    (st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values for default parameters, e = edges since sequence start.
    function automatic logic [3:0] mask(int e, int base);
        int n;
        if (e < base) return 4'h0;
        n = (e - base) / 4 + 1;
        if (n > 4) n = 4;
        return 4'((1 << n) - 1);
    endfunction

    function automatic logic [3:0] exp_rx(int e, bit dbl);
        if (!dbl || e < 58) return mask(e, 28);
        if (e < 86) return 4'h0;
        return mask(e, 86);
    endfunction

    function automatic logic [1:0] exp_st(int e, bit dbl);
        if (e < 28) return 2'd0;
        if (e < 44) return 2'd1;
        if (!dbl) return 2'd3;
        if (e < 58) return 2'd2;
        if (e < 86) return 2'd0;
        if (e < 102) return 2'd1;
        return 2'd3;
    endfunction

    function automatic logic exp_rdy(int e, bit dbl);
        return e >= (dbl ? 102 : 44);
    endfunction

    function automatic logic exp_ck(int e, bit dbl);
        int r;
        r = dbl ? 102 : 44;
        return (e >= r + 4) && ((e - r) % 4 == 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a(input bit dbl);
        dbl_a  = dbl;
        srst_a = 1'b0;
        rst_a  = 1'b1;
        step();
        rst_a  = 1'b0;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        if ({rx_a, rdy_a, ck_a, st_a} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_a got %h want 00", {rx_a, rdy_a, ck_a, st_a});
        end
        n_vec++;
        if ({rx_b, rdy_b, ck_b, st_b} !== 5'h00) begin
            n_err++;
            $display("FAIL reset_b got %h want 00", {rx_b, rdy_b, ck_b, st_b});
        end
        n_vec++;
        rst_b = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int e0,
                           input int e1, input bit dbl);
        for (int e = e0; e <= e1; e++) begin
            if (e > e0) step();
            if (rx_a !== exp_rx(e, dbl)) begin
                n_err++;
                $display("FAIL %s rst_x e=%0d got %h want %h",
                         tag, e, rx_a, exp_rx(e, dbl));
            end
            n_vec++;
            if (st_a !== exp_st(e, dbl)) begin
                n_err++;
                $display("FAIL %s state e=%0d got %0d want %0d",
                         tag, e, st_a, exp_st(e, dbl));
            end
            n_vec++;
            if (rdy_a !== exp_rdy(e, dbl)) begin
                n_err++;
                $display("FAIL %s ready e=%0d got %b want %b",
                         tag, e, rdy_a, exp_rdy(e, dbl));
            end
            n_vec++;
            if (ck_a !== exp_ck(e, dbl)) begin
                n_err++;
                $display("FAIL %s cken e=%0d got %b want %b",
                         tag, e, ck_a, exp_ck(e, dbl));
            end
            n_vec++;
        end
    endtask

    task automatic test_single();
        reset_a(1'b0);
        step();
        run_seq("single", 1, 57, 1'b0);
    endtask

    task automatic test_double();
        reset_a(1'b1);
        step();
        run_seq("double_a", 1, 30, 1'b1);
        // Mode change after latching must not cancel the second pass.
        dbl_a = 1'b0;
        step();
        run_seq("double_b", 31, 110, 1'b1);
    endtask

    task automatic test_srst_stage();
        reset_a(1'b0);
        repeat (33) step();
        if (rx_a !== 4'h3 || st_a !== 2'd1) begin
            n_err++;
            $display("FAIL srst_pre got %h/%0d want 3/1", rx_a, st_a);
        end
        n_vec++;
        srst_a = 1'b1;
        step();
        srst_a = 1'b0;
        run_seq("srst_stage", 0, 30, 1'b0);
    endtask

    task automatic test_srst_held();
        reset_a(1'b0);
        repeat (40) step();
        srst_a = 1'b1;
        repeat (40) step();
        if (rx_a !== 4'h0 || st_a !== 2'd0 || rdy_a !== 1'b0) begin
            n_err++;
            $display("FAIL srst_held got %h/%0d/%b want 0/0/0",
                     rx_a, st_a, rdy_a);
        end
        n_vec++;
        srst_a = 1'b0;
        step();
        run_seq("srst_held", 1, 45, 1'b0);
    endtask

    task automatic test_srst_done();
        reset_a(1'b0);
        repeat (48) step();
        if (ck_a !== 1'b1 || rdy_a !== 1'b1) begin
            n_err++;
            $display("FAIL done_pre got ck=%b rdy=%b want 1/1", ck_a, rdy_a);
        end
        n_vec++;
        repeat (3) step();
        dbl_a  = 1'b1;
        srst_a = 1'b1;
        step();
        srst_a = 1'b0;
        run_seq("srst_done", 0, 110, 1'b1);
    endtask

    task automatic test_async();
        reset_a(1'b1);
        step();
        run_seq("async_pre", 1, 50, 1'b1);
        #3;
        rst_a = 1'b1;
        #1;
        if ({rx_a, rdy_a, ck_a, st_a} !== 8'h00) begin
            n_err++;
            $display("FAIL async_clear got %h want 00",
                     {rx_a, rdy_a, ck_a, st_a});
        end
        n_vec++;
        dbl_a = 1'b0;
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        step();
        run_seq("async_post", 1, 50, 1'b0);
    endtask

    task automatic test_corner();
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        for (int e = 0; e <= 9; e++) begin
            logic       x_rx;
            logic       x_rdy;
            logic       x_ck;
            logic [1:0] x_st;
            if (e > 0) step();
            x_rx  = (e >= 1);
            x_rdy = (e >= 2);
            x_ck  = (e >= 4) && (e % 2 == 0);
            x_st  = (e == 0) ? 2'd0 : (e == 1) ? 2'd1 : 2'd3;
            if ({rx_b, rdy_b, ck_b, st_b} !== {x_rx, x_rdy, x_ck, x_st}) begin
                n_err++;
                $display("FAIL corner e=%0d got %b want %b", e,
                         {rx_b, rdy_b, ck_b, st_b},
                         {x_rx, x_rdy, x_ck, x_st});
            end
            n_vec++;
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_a  = 1'b1;
        dbl_a  = 1'b0;
        srst_a = 1'b0;
        rst_b  = 1'b1;
        dbl_b  = 1'b0;
        srst_b = 1'b0;
        test_reset();
        test_single();
        test_double();
        test_srst_stage();
        test_srst_held();
        test_srst_done();
        test_async();
        test_corner();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
